// File: rtl/led_sequencer_if.sv
// Bus bundle shared by the CPU data bus, the LED sequencer and the LED peripheral port.
// The sequencer sits on the slave side; the CPU/peripheral model drives the master side.
interface led_sequencer_if;
  logic        s_de;
  logic [31:0] daddr;
  logic        drw;
  logic [31:0] din;
  logic [31:0] s_dout;
  logic        c_de;
  logic [31:0] c_dout;
  logic        m_de;
  logic        m_drw;
  logic [31:0] m_din;
  logic [31:0] m_dout;
  logic        busy;

  modport slave (
    input  s_de, daddr, drw, din, c_de, m_dout,
    output s_dout, c_dout, m_de, m_drw, m_din, busy
  );

  modport master (
    output s_de, daddr, drw, din, c_de, m_dout,
    input  s_dout, c_dout, m_de, m_drw, m_din, busy
  );
endinterface

// File: rtl/led_sequencer.sv
// Memory-mapped LED pattern sequencer plus fixed-priority arbiter for the LED peripheral port.
// All state moves on the falling clock edge to match the data bus.
module led_sequencer #(
  parameter int CNT_W = 24
) (
  input  logic           clk,
  input  logic           rst,
  led_sequencer_if.slave bus
);

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_PERIOD = 4'd1;
  localparam logic [3:0] REG_LEN    = 4'd2;

  logic             r_en;
  logic             r_oneshot;
  logic             r_ovr;
  logic             r_pend;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_len;
  logic [2:0]       r_idx;
  logic [7:0]       r_pat [8];
  logic [7:0]       r_pendData;

  logic [3:0]       w_regSel;
  logic             w_wr;
  logic             w_ctrlWr;
  logic             w_drain;
  logic             w_counting;
  logic             w_req;
  logic             w_overrun;
  logic             w_enNext;
  logic             w_oneshotNext;
  logic [2:0]       w_idxNext;
  logic [CNT_W-1:0] w_cntNext;
  logic [CNT_W-1:0] w_periodEff;
  logic [31:0]      w_rdata;

  assign w_regSel    = bus.daddr[5:2];
  assign w_wr        = bus.s_de & bus.drw;
  assign w_ctrlWr    = w_wr && (w_regSel == REG_CTRL);
  assign w_drain     = r_pend & ~bus.c_de;
  assign w_periodEff = (r_period == '0) ? CNT_W'(1) : r_period;
  // An overwrite only counts as overrun if the old pattern is not leaving on this same edge.
  assign w_overrun   = w_req & r_pend & ~w_drain;

  // CTRL writes take precedence over a step due on the same edge.
  always_comb begin
    w_enNext      = r_en;
    w_oneshotNext = r_oneshot;
    w_idxNext     = r_idx;
    w_cntNext     = r_cnt;
    w_req         = 1'b0;
    w_counting    = r_en;

    if (w_ctrlWr) begin
      w_enNext      = bus.din[0];
      w_oneshotNext = bus.din[1];
      if (!bus.din[0]) begin
        w_counting = 1'b0;
      end else if (!r_en) begin
        w_counting = 1'b0;
        w_idxNext  = 3'd0;
        w_cntNext  = w_periodEff;
        w_req      = 1'b1;
      end
    end

    if (w_counting) begin
      if (r_cnt <= CNT_W'(1)) begin
        w_cntNext = w_periodEff;
        if ((r_idx == r_len) && w_oneshotNext) begin
          w_enNext = 1'b0;
        end else begin
          w_idxNext = (r_idx == r_len) ? 3'd0 : r_idx + 3'd1;
          w_req     = 1'b1;
        end
      end else begin
        w_cntNext = r_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      r_en       <= 1'b0;
      r_oneshot  <= 1'b0;
      r_ovr      <= 1'b0;
      r_pend     <= 1'b0;
      r_period   <= '0;
      r_cnt      <= '0;
      r_len      <= 3'd0;
      r_idx      <= 3'd0;
      r_pendData <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        r_pat[i] <= 8'd0;
      end
    end else begin
      r_en      <= w_enNext;
      r_oneshot <= w_oneshotNext;
      r_idx     <= w_idxNext;
      r_cnt     <= w_cntNext;
      r_ovr     <= (r_ovr & ~w_ctrlWr) | w_overrun;

      if (w_req) begin
        r_pend     <= 1'b1;
        r_pendData <= r_pat[w_idxNext];
      end else if (w_drain) begin
        r_pend <= 1'b0;
      end

      if (w_wr && (w_regSel == REG_PERIOD)) begin
        r_period <= bus.din[CNT_W-1:0];
      end
      if (w_wr && (w_regSel == REG_LEN)) begin
        r_len <= bus.din[2:0];
      end
      if (w_wr && w_regSel[3]) begin
        r_pat[w_regSel[2:0]] <= bus.din[7:0];
      end
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    if (bus.s_de) begin
      case (w_regSel)
        REG_CTRL:   w_rdata = {25'd0, r_idx, r_ovr, r_pend, r_oneshot, r_en};
        REG_PERIOD: w_rdata = 32'(r_period);
        REG_LEN:    w_rdata = {29'd0, r_len};
        default: begin
          if (w_regSel[3]) begin
            w_rdata = {24'd0, r_pat[w_regSel[2:0]]};
          end
        end
      endcase
    end
  end

  assign bus.s_dout = w_rdata;
  assign bus.c_dout = bus.c_de ? bus.m_dout : 32'd0;
  assign bus.busy   = r_pend;

  // CPU accesses always own the peripheral port; the sequencer waits for a free cycle.
  always_comb begin
    bus.m_de  = 1'b0;
    bus.m_drw = 1'b0;
    bus.m_din = 32'd0;
    if (bus.c_de) begin
      bus.m_de  = 1'b1;
      bus.m_drw = bus.drw;
      bus.m_din = bus.din;
    end else if (r_pend) begin
      bus.m_de  = 1'b1;
      bus.m_drw = 1'b1;
      bus.m_din = {24'd0, r_pendData};
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: expected LED writes come from the step-timing
// arithmetic (first write one cycle after enable, then one every max(PERIOD,1) cycles).
module tb_led_sequencer;

  localparam int CNT_W = 24;
  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_PERIOD = 32'h04;
  localparam logic [31:0] A_LEN    = 32'h08;

  typedef struct {
    int          c;
    logic [31:0] d;
    logic        drw;
  } seqWrite_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [7:0] pat [8];
  seqWrite_t  seqLog[$];
  seqWrite_t  monEntry;

  led_sequencer_if bus ();

  led_sequencer #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Sequencer-owned LED writes, sampled mid-cycle ahead of the falling edge that latches them.
  always @(posedge clk) begin
    #3;
    if (bus.m_de && !bus.c_de) begin
      monEntry.c   = cyc;
      monEntry.d   = bus.m_din;
      monEntry.drw = bus.m_drw;
      seqLog.push_back(monEntry);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpuWrite(input logic [31:0] a, input logic [31:0] d);
    bus.s_de  = 1'b1;
    bus.drw   = 1'b1;
    bus.daddr = a;
    bus.din   = d;
    tick();
    bus.s_de  = 1'b0;
    bus.drw   = 1'b0;
    bus.daddr = 32'd0;
    bus.din   = 32'd0;
  endtask

  task automatic cpuRead(input logic [31:0] a, output logic [31:0] d);
    bus.s_de  = 1'b1;
    bus.drw   = 1'b0;
    bus.daddr = a;
    #1;
    d = bus.s_dout;
    bus.s_de  = 1'b0;
    bus.daddr = 32'd0;
  endtask

  task automatic resetDut;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic programTable(input int p, input int l);
    for (int i = 0; i < 8; i++) cpuWrite(32'h20 + 32'(4 * i), {24'($urandom), pat[i]});
    cpuWrite(A_LEN, 32'(l));
    cpuWrite(A_PERIOD, 32'(p));
  endtask

  task automatic test_reset;
    logic [31:0] r;
    for (int i = 0; i < 8; i++) pat[i] = 8'($urandom_range(1, 255));
    programTable($urandom_range(1, 9), 7);
    cpuWrite(A_CTRL, 32'h3);
    resetDut();
    seqLog.delete();
    checks++;
    if (bus.m_de !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle: m_de=%b busy=%b, required 0 0", bus.m_de, bus.busy);
    end
    checks++;
    if (bus.m_drw !== 1'b0 || bus.m_din !== 32'd0 || bus.c_dout !== 32'd0 || bus.s_dout !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: m_drw=%b m_din=%h c_dout=%h s_dout=%h, required all 0",
               bus.m_drw, bus.m_din, bus.c_dout, bus.s_dout);
    end
    for (int a = 0; a < 16; a++) begin
      if (a < 3 || a >= 8) begin
        cpuRead(32'(4 * a), r);
        checks++;
        if (r !== 32'd0) begin
          failures++;
          $display("[TB] FAIL reset_reg%0d: read %h, required 0", a, r);
        end
        tick();
      end
    end
    checks++;
    if (seqLog.size() != 0) begin
      failures++;
      $display("[TB] FAIL reset_no_write: %0d writes, required 0", seqLog.size());
    end
  endtask

  task automatic test_free_run;
    int p, pe, l, nW, cStart, cEnd, k;
    logic [31:0] r;
    for (int it = 0; it < 4; it++) begin
      resetDut();
      if (it == 0) begin
        p = 4; l = 3;
        pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h04; pat[3] = 8'h08;
        for (int i = 4; i < 8; i++) pat[i] = 8'($urandom);
      end else begin
        p = $urandom_range(0, 5); l = $urandom_range(0, 7);
        for (int i = 0; i < 8; i++) pat[i] = 8'($urandom);
      end
      programTable(p, l);
      pe = (p == 0) ? 1 : p;
      nW = 2 * (l + 1) + 1;
      seqLog.delete();
      cStart = cyc;
      cpuWrite(A_CTRL, 32'h1);
      cEnd = cStart + 1 + pe * (nW - 1);
      while (1) begin
        if (((cyc - cStart - 1) % pe) == 0) begin
          k = (cyc - cStart - 1) / pe;
          cpuRead(A_CTRL, r);
          checks++;
          if (r[6:4] !== 3'(k % (l + 1)) || r[3:0] !== 4'b0101) begin
            failures++;
            $display("[TB] FAIL free_ctrl it%0d step%0d: ctrl=%h, required idx=%0d low=0101",
                     it, k, r, k % (l + 1));
          end
        end
        if (cyc >= cEnd) break;
        tick();
      end
      @(negedge clk);
      checks++;
      if (seqLog.size() != nW) begin
        failures++;
        $display("[TB] FAIL free_count it%0d: %0d writes, required %0d", it, seqLog.size(), nW);
      end
      for (int i = 0; i < nW && i < seqLog.size(); i++) begin
        checks++;
        if (seqLog[i].c != cStart + 1 + pe * i || seqLog[i].d !== {24'd0, pat[i % (l + 1)]} ||
            seqLog[i].drw !== 1'b1) begin
          failures++;
          $display("[TB] FAIL free_write it%0d #%0d: cycle %0d data %h drw %b, required cycle %0d data %h drw 1",
                   it, i, seqLog[i].c - cStart, seqLog[i].d, seqLog[i].drw, 1 + pe * i, pat[i % (l + 1)]);
        end
      end
      tick();
      cpuWrite(A_CTRL, 32'h0);
      tick();
    end
  endtask

  task automatic test_oneshot;
    int p, pe, l, cStart, stopCyc, k;
    logic [31:0] r;
    for (int it = 0; it < 3; it++) begin
      resetDut();
      if (it == 0) begin
        p = 4; l = 3;
        pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h04; pat[3] = 8'h08;
        for (int i = 4; i < 8; i++) pat[i] = 8'($urandom);
      end else begin
        p = $urandom_range(0, 4); l = $urandom_range(0, 7);
        for (int i = 0; i < 8; i++) pat[i] = 8'($urandom);
      end
      programTable(p, l);
      pe = (p == 0) ? 1 : p;
      seqLog.delete();
      cStart = cyc;
      cpuWrite(A_CTRL, 32'h3);
      stopCyc = cStart + 1 + pe * (l + 1);
      while (cyc <= stopCyc) begin
        if (((cyc - cStart - 1) % pe) == 0) begin
          k = (cyc - cStart - 1) / pe;
          cpuRead(A_CTRL, r);
          checks++;
          if (k <= l) begin
            if (r[6:4] !== 3'(k) || r[1:0] !== 2'b11) begin
              failures++;
              $display("[TB] FAIL oneshot_run it%0d step%0d: ctrl=%h, required idx=%0d en=1", it, k, r, k);
            end
          end else begin
            if (r[6:4] !== 3'(l) || r[1:0] !== 2'b10) begin
              failures++;
              $display("[TB] FAIL oneshot_stop it%0d: ctrl=%h, required idx=%0d en=0 oneshot=1", it, r, l);
            end
          end
        end
        tick();
      end
      repeat (2 * pe + 3) tick();
      @(negedge clk);
      checks++;
      if (seqLog.size() != l + 1) begin
        failures++;
        $display("[TB] FAIL oneshot_count it%0d: %0d writes, required %0d", it, seqLog.size(), l + 1);
      end
      for (int i = 0; i <= l && i < seqLog.size(); i++) begin
        checks++;
        if (seqLog[i].d !== {24'd0, pat[i]} || seqLog[i].c != cStart + 1 + pe * i) begin
          failures++;
          $display("[TB] FAIL oneshot_write it%0d #%0d: data %h cycle %0d, required %h cycle %0d",
                   it, i, seqLog[i].d, seqLog[i].c - cStart, pat[i], 1 + pe * i);
        end
      end
      tick();
    end
  endtask

  task automatic test_arbitration;
    int h, cStart;
    logic [31:0] r, cpuData, ledData;
    resetDut();
    for (int i = 0; i < 8; i++) pat[i] = 8'($urandom);
    programTable(1, 3);
    h = $urandom_range(1, 4);
    cStart = cyc;
    cpuWrite(A_CTRL, 32'h1);
    for (int j = 0; j < h; j++) begin
      cpuData = $urandom;
      ledData = $urandom;
      bus.c_de   = 1'b1;
      bus.drw    = 1'b1;
      bus.din    = cpuData;
      bus.m_dout = ledData;
      #1;
      checks++;
      if (bus.m_de !== 1'b1 || bus.m_drw !== 1'b1 || bus.m_din !== cpuData) begin
        failures++;
        $display("[TB] FAIL arb_cpu cycle%0d: m_de=%b m_drw=%b m_din=%h, required 1 1 %h",
                 j, bus.m_de, bus.m_drw, bus.m_din, cpuData);
      end
      checks++;
      if (bus.c_dout !== ledData || bus.busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL arb_held cycle%0d: c_dout=%h busy=%b, required %h 1", j, bus.c_dout, bus.busy, ledData);
      end
      if (j >= 1) begin
        cpuRead(A_CTRL, r);
        bus.drw = 1'b1;
        checks++;
        if (r[3] !== 1'b1) begin
          failures++;
          $display("[TB] FAIL arb_ovr_set cycle%0d: ovr=%b, required 1", j, r[3]);
        end
      end
      tick();
    end
    bus.c_de = 1'b0;
    bus.drw  = 1'b0;
    bus.din  = 32'd0;
    #1;
    checks++;
    if (bus.m_de !== 1'b1 || bus.m_drw !== 1'b1 || bus.m_din !== {24'd0, pat[h % 4]} || bus.c_dout !== 32'd0) begin
      failures++;
      $display("[TB] FAIL arb_newest: m_de=%b m_drw=%b m_din=%h c_dout=%h, required 1 1 %h 0",
               bus.m_de, bus.m_drw, bus.m_din, bus.c_dout, pat[h % 4]);
    end
    cpuRead(A_CTRL, r);
    checks++;
    if (r[3:0] !== 4'b1101) begin
      failures++;
      $display("[TB] FAIL arb_ovr_sticky: ctrl low=%b, required 1101", r[3:0]);
    end
    cpuWrite(A_CTRL, 32'h1);
    cpuRead(A_CTRL, r);
    checks++;
    if (r[3] !== 1'b0 || r[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL arb_ovr_clear: ovr=%b en=%b, required 0 1", r[3], r[0]);
    end
    tick();
    cpuWrite(A_CTRL, 32'h0);
    tick();
  endtask

  task automatic test_restart_stop;
    int p, cStart, c2;
    logic [31:0] r;
    resetDut();
    for (int i = 0; i < 8; i++) pat[i] = 8'($urandom);
    p = $urandom_range(2, 5);
    programTable(p, 7);
    seqLog.delete();
    cStart = cyc;
    cpuWrite(A_CTRL, 32'h1);
    while (cyc < cStart + p) tick();
    cpuWrite(A_CTRL, 32'h0);
    checks++;
    if (bus.m_de !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stop_suppress: m_de=%b busy=%b, required 0 0", bus.m_de, bus.busy);
    end
    cpuRead(A_CTRL, r);
    checks++;
    if (r[6:4] !== 3'd0 || r[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stop_idx: idx=%0d en=%b, required 0 0", r[6:4], r[0]);
    end
    repeat (2 * p) tick();
    @(negedge clk);
    checks++;
    if (seqLog.size() != 1) begin
      failures++;
      $display("[TB] FAIL stop_writes: %0d writes, required 1", seqLog.size());
    end
    tick();

    c2 = cyc;
    cpuWrite(A_CTRL, 32'h1);
    while (cyc < c2 + p + 1) tick();
    cpuWrite(A_CTRL, 32'h1);
    cpuRead(A_CTRL, r);
    checks++;
    if (r[6:4] !== 3'd1 || r[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rewrite_idx: idx=%0d en=%b, required 1 1", r[6:4], r[0]);
    end
    while (cyc < c2 + 2 * p + 1) tick();
    checks++;
    if (bus.m_de !== 1'b1 || bus.m_din !== {24'd0, pat[2]} || bus.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rewrite_timing: m_de=%b m_din=%h busy=%b, required 1 %h 1",
               bus.m_de, bus.m_din, bus.busy, pat[2]);
    end

    bus.c_de = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.c_de = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.m_de !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_drop: busy=%b m_de=%b, required 0 0", bus.busy, bus.m_de);
    end
    seqLog.delete();
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (seqLog.size() != 0) begin
      failures++;
      $display("[TB] FAIL rst_no_write: %0d writes, required 0", seqLog.size());
    end
    tick();
  endtask

  task automatic test_edge_values;
    logic [31:0] r;
    resetDut();
    for (int i = 1; i < 8; i++) pat[i] = 8'($urandom);
    pat[0] = 8'hA5;
    programTable(0, 0);
    cpuWrite(32'h10, $urandom | 32'h1);
    cpuWrite(A_CTRL, 32'h1);
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (bus.m_de !== 1'b1 || bus.m_drw !== 1'b1 || bus.m_din !== 32'h0000_00A5) begin
        failures++;
        $display("[TB] FAIL edge_every_cycle #%0d: m_de=%b m_drw=%b m_din=%h, required 1 1 000000a5",
                 j, bus.m_de, bus.m_drw, bus.m_din);
      end
      tick();
    end
    for (int a = 3; a < 8; a++) begin
      cpuRead(32'(4 * a), r);
      checks++;
      if (r !== 32'd0) begin
        failures++;
        $display("[TB] FAIL edge_unmapped%0d: read %h, required 0", a, r);
      end
      tick();
    end
    cpuRead(A_PERIOD, r);
    checks++;
    if (r !== 32'd0) begin
      failures++;
      $display("[TB] FAIL edge_period_zero: read %h, required 0", r);
    end
    bus.daddr = A_CTRL;
    #1;
    checks++;
    if (bus.s_dout !== 32'd0) begin
      failures++;
      $display("[TB] FAIL edge_no_select: s_dout=%h, required 0", bus.s_dout);
    end
    bus.daddr = 32'd0;
    tick();
    cpuWrite(A_CTRL, 32'h0);
    tick();
  endtask

  initial begin
    bus.s_de   = 1'b0;
    bus.daddr  = 32'd0;
    bus.drw    = 1'b0;
    bus.din    = 32'd0;
    bus.c_de   = 1'b0;
    bus.m_dout = 32'd0;
    tick();
    test_reset();
    test_free_run();
    test_oneshot();
    test_arbitration();
    test_restart_stop();
    test_edge_values();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
